// File: rtl/booth_pkg.sv
// Shared Booth select-code constants and the accumulator FSM state type.
// Also used by the Booth encoder, so the codes stay in one place.
package booth_pkg;

  localparam logic [2:0] BOOTH_M2A = 3'd1;
  localparam logic [2:0] BOOTH_MA  = 3'd2;
  localparam logic [2:0] BOOTH_0   = 3'd3;
  localparam logic [2:0] BOOTH_PA  = 3'd4;
  localparam logic [2:0] BOOTH_P2A = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/booth_digit_accumulator_if.sv
// Start/select/result bundle between the Booth encoder and the accumulator.
// master = encoder side, slave = accumulator side.
interface booth_digit_accumulator_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic                 sel_valid;
  logic [2:0]           sel;
  logic                 sel_ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 err;

  modport master (
    output start, multiplicand, sel_valid, sel,
    input  sel_ready, busy, done, product, err
  );

  modport slave (
    input  start, multiplicand, sel_valid, sel,
    output sel_ready, busy, done, product, err
  );
endinterface

// File: rtl/booth_pp_select.sv
// Booth partial-product select: 0, +-A, +-2A on WIDTH+2 bits.
// Illegal codes (0, 6, 7) yield 0 and raise the illegal flag.
module booth_pp_select
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic [2:0]              sel,
  output logic signed [WIDTH+1:0] pp,
  output logic                    illegal
);

  logic signed [WIDTH+1:0] ax;

  assign ax = {{2{a[WIDTH-1]}}, a};

  // Decode the select code into the signed partial product.
  always_comb begin
    pp      = '0;
    illegal = 1'b0;
    unique case (sel)
      BOOTH_M2A: pp = -(ax <<< 1);
      BOOTH_MA:  pp = -ax;
      BOOTH_0:   pp = '0;
      BOOTH_PA:  pp = ax;
      BOOTH_P2A: pp = ax <<< 1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_digit_accumulator.sv
// Radix-4 Booth digit accumulator: one digit per beat, LSD first.
// Optional macro BOOTH_ERR_CHECK_EN enables the sticky illegal-code flag.
module booth_digit_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = WIDTH / 2
) (
  input logic                      clk,
  input logic                      reset,
  booth_digit_accumulator_if.slave bus
);

  localparam int PW = WIDTH + 2;
  localparam int AW = 2 * WIDTH;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BOOTH_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  state_t                  state;
  logic signed [WIDTH-1:0] a_q;
  logic [AW-1:0]           acc;
  logic [AW-1:0]           acc_nxt;
  logic [AW-1:0]           prod_q;
  logic [AW-1:0]           pp_ext;
  logic [CW-1:0]           cnt;
  logic signed [PW-1:0]    pp;
  logic                    illegal;
  logic                    last;
  logic                    err_q;

  booth_pp_select #(
    .WIDTH(WIDTH)
  ) u_pp (
    .a      (a_q),
    .sel    (bus.sel),
    .pp     (pp),
    .illegal(illegal)
  );

  assign last    = (cnt == CW'(DIGITS - 1));
  assign pp_ext  = {{(AW - PW){pp[PW-1]}}, pp};
  assign acc_nxt = acc + (pp_ext << {cnt, 1'b0});

  // FSM, digit counter, accumulator and product register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      acc    <= '0;
      prod_q <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.multiplicand;
            acc   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.sel_valid) begin
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
            err_q <= err_q | (ERR_EN & illegal);
            if (last) begin
              prod_q <= acc_nxt;
              state  <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel_ready = (state == RUN);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.product   = prod_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// Directed + random bench for booth_digit_accumulator (WIDTH=8).
// Expected products come from A*B with B rebuilt from the digit values.
module tb_booth_digit_accumulator;

  localparam int W = 8;
  localparam int D = 4;

`ifdef BOOTH_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  booth_digit_accumulator_if #(.WIDTH(W)) bus ();

  booth_digit_accumulator #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int dval(input logic [2:0] s);
    case (s)
      3'd1: return -2;
      3'd2: return -1;
      3'd4: return 1;
      3'd5: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_ill(input logic [2:0] s);
    return (s == 3'd0) || (s > 3'd5);
  endfunction

  // dg = {d3,d2,d1,d0}; st = stall cycles before each digit (4 bits each)
  task automatic run(input string tag, input int a, input logic [11:0] dg,
                     input logic [15:0] st, input bit inject);
    int b = 0;
    int cyc = 0;
    int stalls = 0;
    bit ill = 0;
    logic [15:0] exp;
    for (int i = 0; i < D; i++) begin
      b += dval(dg[3*i +: 3]) * (4 ** i);
      stalls += int'(st[4*i +: 4]);
    end
    exp = 16'(a * b);
    bus.multiplicand = a[7:0];
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_errclr"}, 32'(bus.err), 32'd0);
    for (int i = 0; i < D; i++) begin
      for (int s = 0; s < int'(st[4*i +: 4]); s++) begin
        bus.sel_valid = 1'b0;
        step;
        cyc++;
      end
      bus.sel_valid = 1'b1;
      bus.sel = dg[3*i +: 3];
      if (inject && i == 1) begin
        bus.start = 1'b1;
        bus.multiplicand = ~a[7:0];
      end
      chk({tag, "_rdy"}, 32'(bus.sel_ready), 32'd1);
      step;
      cyc++;
      bus.start = 1'b0;
      ill |= is_ill(dg[3*i +: 3]);
      chk({tag, "_err"}, 32'(bus.err), 32'(ERR_EN && ill));
    end
    bus.sel_valid = 1'b0;
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(D + 1 + stalls));
    chk({tag, "_prod"}, 32'(bus.product), 32'(exp));
    step;
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold"}, 32'(bus.product), 32'(exp));
    chk({tag, "_errhold"}, 32'(bus.err), 32'(ERR_EN && ill));
  endtask

  initial begin
    logic [11:0] dg;
    logic [15:0] st;
    int a;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.sel_valid = 1'b0;
    bus.sel = '0;
    step;
    step;
    reset = 1'b0;
    chk("rst_prod", 32'(bus.product), 32'd0);
    chk("rst_rdy", 32'(bus.sel_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    run("p7x3", 7, {3'd3, 3'd3, 3'd4, 3'd2}, 16'h0000, 1'b0);
    chk("p7x3_lit", 32'(bus.product), 32'h0015);
    run("m128", -128, {3'd1, 3'd3, 3'd3, 3'd3}, 16'h0000, 1'b0);
    chk("m128_lit", 32'(bus.product), 32'h4000);
    run("m5", -5, {3'd3, 3'd4, 3'd1, 3'd4}, 16'h0000, 1'b0);
    run("m5stall", -5, {3'd3, 3'd4, 3'd1, 3'd4}, 16'h0110, 1'b0);
    run("ill7", 7, {3'd3, 3'd3, 3'd7, 3'd2}, 16'h0000, 1'b0);
    chk("ill7_lit", 32'(bus.product), 32'hFFF9);

    // Reset mid-product: two digits accepted, then reset.
    bus.multiplicand = 8'd7;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    bus.sel_valid = 1'b1;
    bus.sel = 3'd2;
    step;
    bus.sel = 3'd4;
    step;
    bus.sel_valid = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("mrst_prod", 32'(bus.product), 32'd0);
    chk("mrst_rdy", 32'(bus.sel_ready), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    step;
    chk("mrst_nodone", 32'(bus.done), 32'd0);
    run("post_rst", 7, {3'd3, 3'd3, 3'd4, 3'd2}, 16'h0000, 1'b0);

    // sel_valid in IDLE is ignored, start during RUN is ignored.
    bus.sel_valid = 1'b1;
    bus.sel = 3'd5;
    step;
    bus.sel_valid = 1'b0;
    chk("idle_sv_busy", 32'(bus.busy), 32'd0);
    chk("idle_sv_rdy", 32'(bus.sel_ready), 32'd0);
    run("inject", 23, {3'd4, 3'd1, 3'd5, 3'd2}, 16'h0020, 1'b1);

    for (int k = 0; k < 16; k++) begin
      a = $urandom_range(0, 255) - 128;
      for (int i = 0; i < D; i++) begin
        if ($urandom_range(0, 9) == 0) dg[3*i +: 3] = 3'($urandom_range(6, 7));
        else dg[3*i +: 3] = 3'($urandom_range(1, 5));
        st[4*i +: 4] = 4'($urandom_range(0, 2));
      end
      run("rnd", a, dg, st, k[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
